// File: rtl/video_timing_pkg.sv
// Shared raster timing types, 720p60 defaults, DVI control encodings and stream FSM states.
package video_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } timing_t;

    localparam timing_t TIMING_720P60_H = '{active: 16'd1280, fp: 16'd110, sync: 16'd40, bp: 16'd220};
    localparam timing_t TIMING_720P60_V = '{active: 16'd720,  fp: 16'd5,   sync: 16'd5,  bp: 16'd20};

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned CTRL_W = 2;

    // Bit positions inside ctrl_ch0 = {vsync, hsync}
    localparam int unsigned CTRL_HSYNC_BIT = 0;
    localparam int unsigned CTRL_VSYNC_BIT = 1;
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_SEEK     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_STREAM   = 2'd2
    } stream_state_e;

    // Full period of one axis (active + porches + sync)
    function automatic int unsigned timing_total(timing_t t);
        return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
    endfunction

endpackage

// File: rtl/video_raster_counter.sv
// Free-running h/v raster counters with combinational active/sync decode.
module video_raster_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 32'(TIMING_720P60_H.active),
    parameter int unsigned H_FP     = 32'(TIMING_720P60_H.fp),
    parameter int unsigned H_SYNC   = 32'(TIMING_720P60_H.sync),
    parameter int unsigned H_BP     = 32'(TIMING_720P60_H.bp),
    parameter int unsigned V_ACTIVE = 32'(TIMING_720P60_V.active),
    parameter int unsigned V_FP     = 32'(TIMING_720P60_V.fp),
    parameter int unsigned V_SYNC   = 32'(TIMING_720P60_V.sync),
    parameter int unsigned V_BP     = 32'(TIMING_720P60_V.bp),
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1
) (
    input  logic clk_pix,
    input  logic rst_pix_n,
    output logic active_c_o,
    output logic hsync_c_o,
    output logic vsync_c_o,
    output logic origin_c_o
);

    localparam timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int unsigned H_TOTAL = timing_total(H_T);
    localparam int unsigned V_TOTAL = timing_total(V_T);
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;

    // Pixel counter wraps at end of line and advances the line counter
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end else begin
            h_q <= h_q + HW'(1);
        end
    end

    // Region and sync decode from the registered position
    always_comb begin
        active_c_o = (h_q < H_ACT_END) && (v_q < V_ACT_END);
        hsync_c_o  = ((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? H_POL : !H_POL;
        vsync_c_o  = ((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? V_POL : !V_POL;
        origin_c_o = (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/video_timing_stream.sv
// Raster timing generator that paces a valid/ready pixel stream onto DVI channels.
module video_timing_stream
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 32'(TIMING_720P60_H.active),
    parameter int unsigned H_FP     = 32'(TIMING_720P60_H.fp),
    parameter int unsigned H_SYNC   = 32'(TIMING_720P60_H.sync),
    parameter int unsigned H_BP     = 32'(TIMING_720P60_H.bp),
    parameter int unsigned V_ACTIVE = 32'(TIMING_720P60_V.active),
    parameter int unsigned V_FP     = 32'(TIMING_720P60_V.fp),
    parameter int unsigned V_SYNC   = 32'(TIMING_720P60_V.sync),
    parameter int unsigned V_BP     = 32'(TIMING_720P60_V.bp),
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_first,
    output logic              de,
    output logic [CH_W-1:0]   data_ch0,
    output logic [CH_W-1:0]   data_ch1,
    output logic [CH_W-1:0]   data_ch2,
    output logic [CTRL_W-1:0] ctrl_ch0,
    output logic [CTRL_W-1:0] ctrl_ch1,
    output logic [CTRL_W-1:0] ctrl_ch2,
    output logic              frame_start,
    output logic              underrun,
    input  logic              clr_err
);

    stream_state_e     state_q, state_d;
    logic              live_q;
    logic              de_q;
    logic [PIX_W-1:0]  pix_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              fs_q;
    logic              underrun_q;

    logic active_c, hsync_c, vsync_c, origin_c;
    logic accept_c, show_c, urun_c;

    video_raster_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .H_POL    (H_POL),    .V_POL (V_POL)
    ) u_raster (
        .clk_pix    (clk_pix),
        .rst_pix_n  (rst_pix_n),
        .active_c_o (active_c),
        .hsync_c_o  (hsync_c),
        .vsync_c_o  (vsync_c),
        .origin_c_o (origin_c)
    );

    // Lock/stream decisions for the current raster position
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        show_c   = 1'b0;
        urun_c   = 1'b0;
        if (!enable) begin
            state_d = ST_SEEK;
        end else begin
            case (state_q)
                ST_SEEK: begin
                    // Drain junk; the start-of-frame beat is left waiting on the bus
                    if (s_valid && s_first) begin
                        state_d = ST_WAIT_SOF;
                    end else begin
                        accept_c = live_q;
                    end
                end
                ST_WAIT_SOF: begin
                    if (origin_c) begin
                        if (s_valid) begin
                            accept_c = 1'b1;
                            show_c   = 1'b1;
                            state_d  = ST_STREAM;
                        end else begin
                            urun_c  = 1'b1;
                            state_d = ST_SEEK;
                        end
                    end
                end
                ST_STREAM: begin
                    if (active_c) begin
                        if (!s_valid) begin
                            urun_c  = 1'b1;
                            state_d = ST_SEEK;
                        end else if (s_first && !origin_c) begin
                            // Early start-of-frame: hold it and blank until next frame
                            state_d = ST_WAIT_SOF;
                        end else begin
                            accept_c = 1'b1;
                            show_c   = 1'b1;
                        end
                    end
                end
                default: state_d = ST_SEEK;
            endcase
        end
    end

    assign s_ready = accept_c;

    // State and output register stage; black is driven whenever no beat is shown
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q                <= ST_SEEK;
            live_q                 <= 1'b0;
            de_q                   <= 1'b0;
            pix_q                  <= '0;
            ctrl_q[CTRL_HSYNC_BIT] <= !H_POL;
            ctrl_q[CTRL_VSYNC_BIT] <= !V_POL;
            fs_q                   <= 1'b0;
            underrun_q             <= 1'b0;
        end else begin
            state_q                <= state_d;
            live_q                 <= 1'b1;
            de_q                   <= active_c;
            pix_q                  <= show_c ? s_data : '0;
            ctrl_q[CTRL_HSYNC_BIT] <= hsync_c;
            ctrl_q[CTRL_VSYNC_BIT] <= vsync_c;
            fs_q                   <= origin_c;
            if (urun_c) begin
                underrun_q <= 1'b1;
            end else if (clr_err) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign de          = de_q;
    assign data_ch0    = pix_q[7:0];
    assign data_ch1    = pix_q[15:8];
    assign data_ch2    = pix_q[23:16];
    assign ctrl_ch0    = ctrl_q;
    assign ctrl_ch1    = CTRL_IDLE;
    assign ctrl_ch2    = CTRL_IDLE;
    assign frame_start = fs_q;
    assign underrun    = underrun_q;

endmodule
